// File: rtl/mips_bus_arbiter.sv
// rtl/mips_bus_arbiter.sv - two-master Avalon arbiter (fetch m0, data m1) onto one shared memory slave; ARB_ROUND_ROBIN_EN selects round-robin IDLE tie-break
module mips_bus_arbiter (
   input  logic        clk,
   input  logic        reset,
   // port 0: instruction fetch master
   input  logic [31:0] m0_address,
   input  logic [31:0] m0_writedata,
   input  logic        m0_read,
   input  logic        m0_write,
   input  logic [3:0]  m0_byteenable,
   output logic        m0_waitrequest,
   output logic [31:0] m0_readdata,
   // port 1: data load/store master
   input  logic [31:0] m1_address,
   input  logic [31:0] m1_writedata,
   input  logic        m1_read,
   input  logic        m1_write,
   input  logic [3:0]  m1_byteenable,
   output logic        m1_waitrequest,
   output logic [31:0] m1_readdata,
   // shared memory slave
   output logic [31:0] s_address,
   output logic [31:0] s_writedata,
   output logic        s_read,
   output logic        s_write,
   output logic [3:0]  s_byteenable,
   input  logic        s_waitrequest,
   input  logic [31:0] s_readdata,
   // status
   output logic [1:0]  grant,
   output logic        protocol_err
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      OWN0 = 2'd1,
      OWN1 = 2'd2
   } state_t;

   state_t state;
   state_t state_next;

   // 0 = m0 completed last, 1 = m1 completed last
   logic last_owner;
   logic last_owner_next;

   logic m0_req;
   logic m1_req;
   logic tie_pick_m1;
   logic proto_viol;

   assign m0_req = m0_read | m0_write;
   assign m1_req = m1_read | m1_write;

   // a read+write pair on either port is a master bug worth latching
   assign proto_viol = (m0_read & m0_write) | (m1_read & m1_write);

`ifdef ARB_ROUND_ROBIN_EN
   // alternate: the port that did not finish last wins the tie
   assign tie_pick_m1 = ~last_owner;
`else
   // data port always wins a tie so loads/stores are never starved by fetch
   assign tie_pick_m1 = 1'b1;
`endif

   assign grant       = {state == OWN1, state == OWN0};
   assign m0_readdata = s_readdata;
   assign m1_readdata = s_readdata;

   // state, last-owner and sticky error registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= IDLE;
         last_owner   <= 1'b1;
         protocol_err <= 1'b0;
      end else begin
         state        <= state_next;
         last_owner   <= last_owner_next;
         protocol_err <= protocol_err | proto_viol;
      end
   end

   // next-state: hold ownership until completion or the owner withdraws
   always_comb begin
      state_next      = state;
      last_owner_next = last_owner;
      case (state)
         IDLE: begin
            if (m0_req && m1_req) begin
               state_next = tie_pick_m1 ? OWN1 : OWN0;
            end else if (m0_req) begin
               state_next = OWN0;
            end else if (m1_req) begin
               state_next = OWN1;
            end
         end
         OWN0: begin
            if (!m0_req) begin
               state_next = IDLE;
            end else if (!s_waitrequest) begin
               last_owner_next = 1'b0;
               state_next      = m1_req ? OWN1 : IDLE;
            end
         end
         OWN1: begin
            if (!m1_req) begin
               state_next = IDLE;
            end else if (!s_waitrequest) begin
               last_owner_next = 1'b1;
               state_next      = m0_req ? OWN0 : IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // slave mux and waitrequest steering; reset forces the bus quiet
   always_comb begin
      s_address      = 32'd0;
      s_writedata    = 32'd0;
      s_byteenable   = 4'd0;
      s_read         = 1'b0;
      s_write        = 1'b0;
      m0_waitrequest = 1'b1;
      m1_waitrequest = 1'b1;
      case (state)
         OWN0: begin
            s_address      = m0_address;
            s_writedata    = m0_writedata;
            s_byteenable   = m0_byteenable;
            s_write        = m0_write;
            s_read         = m0_read & ~m0_write;
            m0_waitrequest = s_waitrequest;
         end
         OWN1: begin
            s_address      = m1_address;
            s_writedata    = m1_writedata;
            s_byteenable   = m1_byteenable;
            s_write        = m1_write;
            s_read         = m1_read & ~m1_write;
            m1_waitrequest = s_waitrequest;
         end
         default: begin
         end
      endcase
      if (reset) begin
         s_read         = 1'b0;
         s_write        = 1'b0;
         m0_waitrequest = 1'b1;
         m1_waitrequest = 1'b1;
      end
   end

endmodule
